// File: rtl/eth_mdio_master.sv
// rtl/eth_mdio_master.sv - Clause-22 MDIO management master (MDC/MDIO frame engine)
//
// Turns one register-access command into a serial MDC/MDIO frame and returns read data.
// Parameters:
//   CLK_DIV      clk_i cycles per MDC half-period (>= 4); MDC period = 2*CLK_DIV cycles
//   PREAMBLE_EN  1: 32-bit all-ones preamble, 64-bit frame; 0: no preamble, 32-bit frame
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o    command handshake (ready only in IDLE)
//   cmd_write_i                  1 = write (OP=01), 0 = read (OP=10)
//   cmd_phy_addr_i, cmd_reg_addr_i, cmd_wdata_i   PHYAD, REGAD, write data
//   rsp_valid_o                  one-cycle pulse when a frame completes
//   rsp_rdata_o, rsp_err_o       read data / no-PHY flag (updated only by reads)
//   busy_o                       frame in progress (SHIFT or DONE)
//   mdc_o, mdio_o, mdio_oe_o     pad-side MDC, MDIO value and MDIO output enable
//   mdio_i                       MDIO from pad (asynchronous)

module eth_mdio_master #(
    parameter int CLK_DIV     = 4,
    parameter bit PREAMBLE_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [4:0]  cmd_phy_addr_i,
    input  logic [4:0]  cmd_reg_addr_i,
    input  logic [15:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic        mdc_o,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    input  logic        mdio_i
);

    localparam int N     = PREAMBLE_EN ? 64 : 32;
    localparam int DIV_W = $clog2(2 * CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [5:0]       BIT_LAST = 6'(N - 1);
    // The last 18 bits of every frame are TA(2) + DATA(16).
    localparam logic [5:0]       TA1_BIT  = 6'(N - 18);
    localparam logic [5:0]       TA2_BIT  = 6'(N - 17);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       bit_cnt;
    logic [63:0]      shreg;
    logic             is_write;
    logic [15:0]      rd_sh;
    logic             mdio_s1;
    logic             mdio_s2;

    logic             accept;
    logic             bit_end;
    logic             last_bit;
    logic [31:0]      frame_hdr;
    logic [63:0]      frame_load;

    assign accept   = cmd_valid_i && (state == S_IDLE);
    assign bit_end  = (state == S_SHIFT) && (div_cnt == DIV_LAST);
    assign last_bit = bit_end && (bit_cnt == BIT_LAST);

    assign cmd_ready_o = (state == S_IDLE);
    assign busy_o      = (state != S_IDLE);

    // Read frames leave TA/DATA undriven, so their slot contents are irrelevant.
    always_comb begin
        frame_hdr = {2'b01,
                     cmd_write_i ? 2'b01 : 2'b10,
                     cmd_phy_addr_i,
                     cmd_reg_addr_i,
                     cmd_write_i ? 2'b10 : 2'b11,
                     cmd_write_i ? cmd_wdata_i : 16'hFFFF};
        frame_load = PREAMBLE_EN ? {32'hFFFF_FFFF, frame_hdr} : {frame_hdr, 32'h0};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)   state_nxt = S_SHIFT;
            S_SHIFT: if (last_bit) state_nxt = S_DONE;
            S_DONE:                state_nxt = S_IDLE;
            default:               state_nxt = S_IDLE;
        endcase
    end

    // Two-flop synchronizer for the asynchronous pad input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mdio_s1 <= 1'b1;
            mdio_s2 <= 1'b1;
        end else begin
            mdio_s1 <= mdio_i;
            mdio_s2 <= mdio_s1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            is_write    <= 1'b0;
            rd_sh       <= '0;
            mdc_o       <= 1'b0;
            mdio_o      <= 1'b1;
            mdio_oe_o   <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        // First bit goes straight to the pin; the rest wait in shreg.
                        mdio_o    <= frame_load[63];
                        shreg     <= {frame_load[62:0], 1'b0};
                        mdio_oe_o <= 1'b1;
                        mdc_o     <= 1'b0;
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
                        is_write  <= cmd_write_i;
                    end
                end
                S_SHIFT: begin
                    div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
                    if (div_cnt == DIV_HALF) begin
                        mdc_o <= 1'b1;
                    end
                    if (bit_end) begin
                        // Capture at the end of the high phase: second TA bit, then DATA[15:0].
                        if (bit_cnt >= TA2_BIT) begin
                            rd_sh <= {rd_sh[14:0], mdio_s2};
                        end
                        mdc_o <= 1'b0;
                        if (last_bit) begin
                            mdio_o      <= 1'b1;
                            mdio_oe_o   <= 1'b0;
                            rsp_valid_o <= 1'b1;
                            if (!is_write) begin
                                // rd_sh[15] holds the second TA sample at this point.
                                rsp_rdata_o <= {rd_sh[14:0], mdio_s2};
                                rsp_err_o   <= rd_sh[15];
                            end
                        end else begin
                            mdio_o    <= shreg[63];
                            shreg     <= {shreg[62:0], 1'b0};
                            bit_cnt   <= bit_cnt + 6'd1;
                            mdio_oe_o <= is_write || ((bit_cnt + 6'd1) < TA1_BIT);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_mdio_master.sv
// tb/tb_eth_mdio_master.sv - self-checking bench for eth_mdio_master (two configurations)

module tb_eth_mdio_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Unit 0: CLK_DIV=4 with preamble (64-bit frame). Unit 1: CLK_DIV=8, no preamble (32-bit frame).
    logic [1:0]       rst;
    logic [1:0]       cmd_valid;
    logic [1:0]       cmd_write;
    logic [1:0][4:0]  cmd_phy;
    logic [1:0][4:0]  cmd_reg;
    logic [1:0][15:0] cmd_wdata;
    logic [1:0]       cmd_ready;
    logic [1:0]       rsp_valid;
    logic [1:0][15:0] rsp_rdata;
    logic [1:0]       rsp_err;
    logic [1:0]       busy;
    logic [1:0]       mdc;
    logic [1:0]       mdio_out;
    logic [1:0]       mdio_oe;
    logic [1:0]       mdio_in = 2'b11;

    eth_mdio_master #(.CLK_DIV(4), .PREAMBLE_EN(1'b1)) dut0 (
        .clk_i(clk), .rst_i(rst[0]),
        .cmd_valid_i(cmd_valid[0]), .cmd_ready_o(cmd_ready[0]), .cmd_write_i(cmd_write[0]),
        .cmd_phy_addr_i(cmd_phy[0]), .cmd_reg_addr_i(cmd_reg[0]), .cmd_wdata_i(cmd_wdata[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0]),
        .busy_o(busy[0]), .mdc_o(mdc[0]), .mdio_o(mdio_out[0]), .mdio_oe_o(mdio_oe[0]),
        .mdio_i(mdio_in[0])
    );

    eth_mdio_master #(.CLK_DIV(8), .PREAMBLE_EN(1'b0)) dut1 (
        .clk_i(clk), .rst_i(rst[1]),
        .cmd_valid_i(cmd_valid[1]), .cmd_ready_o(cmd_ready[1]), .cmd_write_i(cmd_write[1]),
        .cmd_phy_addr_i(cmd_phy[1]), .cmd_reg_addr_i(cmd_reg[1]), .cmd_wdata_i(cmd_wdata[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1]),
        .busy_o(busy[1]), .mdc_o(mdc[1]), .mdio_o(mdio_out[1]), .mdio_oe_o(mdio_oe[1]),
        .mdio_i(mdio_in[1])
    );

    typedef struct {
        int          u;
        bit          wr;
        logic [4:0]  pa;
        logic [4:0]  ra;
        logic [15:0] wd;
        bit          phy_on;
        logic [15:0] phy_d;
        logic [15:0] exp_rd;
        bit          exp_err;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int          acc_cnt[2];
    int          acc_cyc[2];
    int          prev_acc_cyc[2];
    int          rv_cnt[2];
    int          rv_lat[2];
    int          rise_cnt[2];
    int          ready_bad[2];
    int          busy_bad[2];
    logic [63:0] got_bits[2];
    logic [63:0] got_oe[2];
    bit          in_frame[2];
    bit          cur_wr[2];
    bit          phy_on[2];
    logic [15:0] phy_data[2];
    logic [1:0]  prev_mdc = 2'b00;

    logic [15:0] mdl_rd[2];
    bit          mdl_err[2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int frame_len(int u);
        return (u == 1) ? 32 : 64;
    endfunction

    // PHY behaviour for bit b of a read frame: release on TA1, 0 on TA2, then DATA MSB first.
    function automatic logic phy_bit(int u, int b);
        int ta1;
        ta1 = frame_len(u) - 18;
        if (!phy_on[u]) return 1'b1;
        if (b <= ta1) return 1'b1;
        if (b == ta1 + 1) return 1'b0;
        return phy_data[u][15 - (b - ta1 - 2)];
    endfunction

    // Expected frame, left-aligned in 64 bits.
    function automatic logic [63:0] ref_frame(int u, bit wr, logic [4:0] pa, logic [4:0] ra,
                                              logic [15:0] d);
        logic [31:0] h;
        h = {2'b01, wr ? 2'b01 : 2'b10, pa, ra, 2'b10, d};
        return (u == 1) ? {h, 32'h0} : {32'hFFFF_FFFF, h};
    endfunction

    function automatic logic [63:0] ref_oe(int u, bit wr);
        logic [63:0] m;
        int n;
        n = frame_len(u);
        m = '0;
        for (int i = 0; i < n; i++) m[63 - i] = wr || (i < n - 18);
        return m;
    endfunction

    // Monitor + PHY model, sampled on the falling edge.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst[u]) begin
                in_frame[u] = 1'b0;
                mdio_in[u]  = 1'b1;
            end else begin
                if (in_frame[u]) begin
                    if (cmd_ready[u]) ready_bad[u]++;
                    if (!busy[u]) busy_bad[u]++;
                    if (mdc[u] && !prev_mdc[u]) begin
                        if (rise_cnt[u] < 64) begin
                            got_bits[u][63 - rise_cnt[u]] = mdio_out[u];
                            got_oe[u][63 - rise_cnt[u]]   = mdio_oe[u];
                        end
                        if (!cur_wr[u]) mdio_in[u] = phy_bit(u, rise_cnt[u]);
                        rise_cnt[u]++;
                    end
                    if (rsp_valid[u]) begin
                        rv_cnt[u]++;
                        rv_lat[u]   = cyc - acc_cyc[u];
                        in_frame[u] = 1'b0;
                        mdio_in[u]  = 1'b1;
                    end
                end else if (rsp_valid[u]) begin
                    rv_cnt[u]++;
                end
                if (cmd_valid[u] && cmd_ready[u]) begin
                    prev_acc_cyc[u] = acc_cyc[u];
                    acc_cyc[u]      = cyc;
                    acc_cnt[u]++;
                    in_frame[u]     = 1'b1;
                    cur_wr[u]       = cmd_write[u];
                    rise_cnt[u]     = 0;
                    got_bits[u]     = '0;
                    got_oe[u]       = '0;
                end
            end
            prev_mdc[u] = mdc[u];
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        cmd_write[v.u] = v.wr;
        cmd_phy[v.u]   = v.pa;
        cmd_reg[v.u]   = v.ra;
        cmd_wdata[v.u] = v.wd;
        phy_on[v.u]    = v.phy_on;
        phy_data[v.u]  = v.phy_d;
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        int u;
        int a0;
        int r0;
        int rb0;
        int bb0;
        logic [63:0] ef;
        logic [63:0] eo;
        u   = v.u;
        a0  = acc_cnt[u];
        r0  = rv_cnt[u];
        rb0 = ready_bad[u];
        bb0 = busy_bad[u];
        drive_cmd(v);
        cmd_valid[u] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (acc_cnt[u] != a0) break;
        end
        cmd_valid[u] = 1'b0;
        chk({tag, " accept"}, 64'(acc_cnt[u] - a0), 64'd1);
        for (int i = 0; i < 2000; i++) begin
            if (rv_cnt[u] != r0) break;
            @(posedge clk); #1;
        end
        chk({tag, " rsp_pulses"}, 64'(rv_cnt[u] - r0), 64'd1);
        chk({tag, " ready_after"}, 64'(cmd_ready[u]), 64'd1);
        ef = ref_frame(u, v.wr, v.pa, v.ra, v.wd);
        eo = ref_oe(u, v.wr);
        chk({tag, " latency"}, 64'(rv_lat[u]), 64'd513);
        chk({tag, " mdc_pulses"}, 64'(rise_cnt[u]), 64'(frame_len(u)));
        chk({tag, " mdio_stream"}, got_bits[u] & eo, ef & eo);
        chk({tag, " mdio_oe"}, got_oe[u], eo);
        chk({tag, " rdata"}, 64'(rsp_rdata[u]), 64'(v.exp_rd));
        chk({tag, " err"}, 64'(rsp_err[u]), 64'(v.exp_err));
        chk({tag, " ready_in_frame"}, 64'(ready_bad[u] - rb0), 64'd0);
        chk({tag, " busy_in_frame"}, 64'(busy_bad[u] - bb0), 64'd0);
        mdl_rd[v.u]  = v.exp_rd;
        mdl_err[v.u] = v.exp_err;
    endtask

    initial begin
        vec_t tbl[7];
        vec_t v;
        int a0;
        int r0;

        tbl[0] = '{0, 1'b1, 5'd1,  5'd0,  16'h1140, 1'b0, 16'h0000, 16'h0000, 1'b0};
        tbl[1] = '{0, 1'b0, 5'd3,  5'd2,  16'h0000, 1'b1, 16'h0141, 16'h0141, 1'b0};
        tbl[2] = '{0, 1'b0, 5'd4,  5'd1,  16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b1};
        tbl[3] = '{0, 1'b1, 5'd4,  5'd1,  16'hBEEF, 1'b0, 16'h0000, 16'hFFFF, 1'b1};
        tbl[4] = '{1, 1'b0, 5'd2,  5'd9,  16'h0000, 1'b1, 16'h5A3C, 16'h5A3C, 1'b0};
        tbl[5] = '{1, 1'b1, 5'd31, 5'd31, 16'hFFFF, 1'b0, 16'h0000, 16'h5A3C, 1'b0};
        tbl[6] = '{0, 1'b0, 5'd31, 5'd31, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0};

        rst       = 2'b11;
        cmd_valid = 2'b00;
        cmd_write = 2'b00;
        cmd_phy   = '0;
        cmd_reg   = '0;
        cmd_wdata = '0;
        for (int u = 0; u < 2; u++) begin
            acc_cnt[u] = 0; acc_cyc[u] = 0; prev_acc_cyc[u] = 0; rv_cnt[u] = 0; rv_lat[u] = 0;
            rise_cnt[u] = 0; ready_bad[u] = 0; busy_bad[u] = 0; got_bits[u] = '0; got_oe[u] = '0;
            in_frame[u] = 1'b0; cur_wr[u] = 1'b0; phy_on[u] = 1'b0; phy_data[u] = '0;
            mdl_rd[u] = '0; mdl_err[u] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 2'b00;

        for (int u = 0; u < 2; u++) begin
            chk($sformatf("reset%0d mdc", u), 64'(mdc[u]), 64'd0);
            chk($sformatf("reset%0d mdio", u), 64'(mdio_out[u]), 64'd1);
            chk($sformatf("reset%0d oe", u), 64'(mdio_oe[u]), 64'd0);
            chk($sformatf("reset%0d rsp_valid", u), 64'(rsp_valid[u]), 64'd0);
            chk($sformatf("reset%0d rdata", u), 64'(rsp_rdata[u]), 64'd0);
            chk($sformatf("reset%0d err", u), 64'(rsp_err[u]), 64'd0);
            chk($sformatf("reset%0d busy", u), 64'(busy[u]), 64'd0);
            chk($sformatf("reset%0d ready", u), 64'(cmd_ready[u]), 64'd1);
        end

        for (int i = 0; i < 7; i++) run_cmd(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back: cmd_valid held through two accepts.
        a0 = acc_cnt[0];
        r0 = rv_cnt[0];
        v  = '{0, 1'b1, 5'd7, 5'd4, 16'h8001, 1'b0, 16'h0, mdl_rd[0], mdl_err[0]};
        drive_cmd(v);
        cmd_valid[0] = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            @(posedge clk); #1;
            if (acc_cnt[0] - a0 >= 2) break;
        end
        cmd_valid[0] = 1'b0;
        chk("b2b accepts", 64'(acc_cnt[0] - a0), 64'd2);
        chk("b2b spacing", 64'(acc_cyc[0] - prev_acc_cyc[0]), 64'd514);
        for (int i = 0; i < 700; i++) begin
            if (rv_cnt[0] - r0 >= 2) break;
            @(posedge clk); #1;
        end
        repeat (20) @(posedge clk);
        #1;
        chk("b2b rsp_pulses", 64'(rv_cnt[0] - r0), 64'd2);

        // Reset during bit 20 of a write frame.
        v = '{0, 1'b1, 5'd9, 5'd3, 16'h2468, 1'b0, 16'h0, 16'h0, 1'b0};
        drive_cmd(v);
        a0 = acc_cnt[0];
        cmd_valid[0] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (acc_cnt[0] != a0) break;
        end
        cmd_valid[0] = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (rise_cnt[0] >= 21) break;
            @(posedge clk); #1;
        end
        chk("rst_mid bit", 64'(rise_cnt[0]), 64'd21);
        r0 = rv_cnt[0];
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        chk("rst_mid mdc", 64'(mdc[0]), 64'd0);
        chk("rst_mid oe", 64'(mdio_oe[0]), 64'd0);
        chk("rst_mid mdio", 64'(mdio_out[0]), 64'd1);
        chk("rst_mid ready", 64'(cmd_ready[0]), 64'd1);
        chk("rst_mid busy", 64'(busy[0]), 64'd0);
        repeat (600) @(posedge clk);
        #1;
        chk("rst_mid no_rsp", 64'(rv_cnt[0] - r0), 64'd0);
        mdl_rd[0]  = 16'h0;
        mdl_err[0] = 1'b0;
        v = '{0, 1'b1, 5'd9, 5'd3, 16'h2468, 1'b0, 16'h0, mdl_rd[0], mdl_err[0]};
        run_cmd(v, "after_rst");

        // Randomized commands against the behavioural model.
        for (int i = 0; i < 8; i++) begin
            v.u      = i % 2;
            v.wr     = 1'($urandom_range(0, 1));
            v.pa     = 5'($urandom);
            v.ra     = 5'($urandom);
            v.wd     = 16'($urandom);
            v.phy_on = ($urandom_range(0, 3) != 0);
            v.phy_d  = 16'($urandom);
            if (v.wr) begin
                v.exp_rd  = mdl_rd[v.u];
                v.exp_err = mdl_err[v.u];
            end else if (v.phy_on) begin
                v.exp_rd  = v.phy_d;
                v.exp_err = 1'b0;
            end else begin
                v.exp_rd  = 16'hFFFF;
                v.exp_err = 1'b1;
            end
            run_cmd(v, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
